vga_bounce_renderer: RTL and testbench

Pixel-generation stage directly downstream of the VGA sync generator. It consumes the generator's registered sync, blank and pixel-coordinate outputs and produces 12-bit RGB plus re-aligned sync signals for the DAC/pins. The picture is a selectable background pattern with a square box that moves one step per frame and bounces off the visible-area edges. A 2-stage pipeline keeps colour and sync aligned.

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_box_mover.sv | 66 ++++++
 rtl/vga_bounce_renderer.sv | 129 ++++++++++++
 tb/tb_vga_bounce_renderer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared display constants and types for the VGA pixel pipeline.
package vga_pkg;
    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    typedef enum logic [1:0] {
        MODE_BOX     = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SOLID   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;
endpackage

// File: rtl/vga_box_mover.sv
// Per-frame box position update; each axis steps and bounces off the visible edges.
module vga_box_mover #(
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int BOX_SIZE  = 32,
    parameter int BOX_STEP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    output logic [10:0] box_x,
    output logic [9:0]  box_y
);
    localparam logic [11:0] SIZE12 = 12'(BOX_SIZE);
    localparam logic [11:0] STEP12 = 12'(BOX_STEP);
    localparam logic [11:0] H12    = 12'(H_DISPLAY);
    localparam logic [11:0] V12    = 12'(V_DISPLAY);

    logic        dir_x, dir_y;
    logic [11:0] next_x, next_y;
    logic        next_dx, next_dy;

    // Returns {dir, pos}; 12-bit math leaves headroom so the edge test never wraps.
    function automatic logic [12:0] next_axis(input logic [11:0] pos, input logic dir,
                                              input logic [11:0] lim);
        logic [11:0] p;
        logic        d;
        if (dir) begin
            if (pos + SIZE12 + STEP12 > lim) begin
                p = lim - SIZE12;
                d = 1'b0;
            end else begin
                p = pos + STEP12;
                d = 1'b1;
            end
        end else begin
            if (pos < STEP12) begin
                p = '0;
                d = 1'b1;
            end else begin
                p = pos - STEP12;
                d = 1'b0;
            end
        end
        return {d, p};
    endfunction

    always_comb begin
        {next_dx, next_x} = next_axis({1'b0, box_x}, dir_x, H12);
        {next_dy, next_y} = next_axis({2'b0, box_y}, dir_y, V12);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            box_x <= '0;
            box_y <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (tick) begin
            box_x <= next_x[10:0];
            box_y <= next_y[9:0];
            dir_x <= next_dx;
            dir_y <= next_dy;
        end
    end
endmodule

// File: rtl/vga_bounce_renderer.sv
// Two-stage pixel renderer: pattern + bouncing box, with syncs delayed to match.
module vga_bounce_renderer #(
    parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
    parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
    parameter int BOX_SIZE  = 32,
    parameter int BOX_STEP  = 2
) (
    input  logic        vga_clk_in,
    input  logic        reset_in,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        display_on_in,
    input  logic [10:0] pixel_x_in,
    input  logic [9:0]  pixel_y_in,
    input  logic [1:0]  mode_in,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [3:0]  red_out,
    output logic [3:0]  green_out,
    output logic [3:0]  blue_out,
    output logic        frame_tick_out
);
    import vga_pkg::*;

    localparam logic [11:0] SIZE12 = 12'(BOX_SIZE);
    localparam int          BAR_W  = H_DISPLAY / 8;

    logic        vs_prev, tick;
    mode_t       mode_q;
    logic [10:0] box_x;
    logic [9:0]  box_y;

    assign tick = vs_prev & ~v_sync_in;

    vga_box_mover #(
        .H_DISPLAY(H_DISPLAY), .V_DISPLAY(V_DISPLAY),
        .BOX_SIZE(BOX_SIZE),   .BOX_STEP(BOX_STEP)
    ) u_mover (
        .clk(vga_clk_in), .reset(reset_in), .tick(tick),
        .box_x(box_x), .box_y(box_y)
    );

    always_ff @(posedge vga_clk_in) begin
        if (reset_in) begin
            vs_prev        <= 1'b1;
            frame_tick_out <= 1'b0;
            mode_q         <= MODE_BOX;
        end else begin
            vs_prev        <= v_sync_in;
            frame_tick_out <= tick;
            if (tick) mode_q <= mode_t'(mode_in);
        end
    end

    // Stage 1: geometry decode
    logic [11:0] x12, y12, bx12, by12;
    logic        in_box_c;
    logic [2:0]  bar_c;

    always_comb begin
        x12      = {1'b0, pixel_x_in};
        y12      = {2'b0, pixel_y_in};
        bx12     = {1'b0, box_x};
        by12     = {2'b0, box_y};
        in_box_c = (x12 >= bx12) && (x12 < bx12 + SIZE12) &&
                   (y12 >= by12) && (y12 < by12 + SIZE12);
        // Comparator chain instead of x / BAR_W
        bar_c = '0;
        for (int k = 1; k < 8; k++)
            if (x12 >= 12'(k * BAR_W)) bar_c = 3'(k);
    end

    logic       s1_on, s1_hs, s1_vs, s1_in_box, s1_checker;
    logic [2:0] s1_bar;

    always_ff @(posedge vga_clk_in) begin
        if (reset_in) begin
            s1_on      <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_in_box  <= 1'b0;
            s1_checker <= 1'b0;
            s1_bar     <= '0;
        end else begin
            s1_on      <= display_on_in;
            s1_hs      <= h_sync_in;
            s1_vs      <= v_sync_in;
            s1_in_box  <= in_box_c;
            s1_checker <= pixel_x_in[5] ^ pixel_y_in[5];
            s1_bar     <= bar_c;
        end
    end

    // Stage 2: colour select
    rgb_t col, rgb_q;

    always_comb begin
        col = '0;
        if (!s1_on)
            col = '0;
        else if (mode_q == MODE_SOLID)
            col = rgb_t'(12'h00F);
        else if (s1_in_box)
            col = rgb_t'(12'hFFF);
        else begin
            case (mode_q)
                MODE_BARS:    col = '{r: {4{s1_bar[2]}}, g: {4{s1_bar[1]}}, b: {4{s1_bar[0]}}};
                MODE_CHECKER: col = s1_checker ? rgb_t'(12'h888) : rgb_t'(12'h222);
                default:      col = '0;
            endcase
        end
    end

    always_ff @(posedge vga_clk_in) begin
        if (reset_in) begin
            h_sync_out <= 1'b1;
            v_sync_out <= 1'b1;
            rgb_q      <= '0;
        end else begin
            h_sync_out <= s1_hs;
            v_sync_out <= s1_vs;
            rgb_q      <= col;
        end
    end

    assign red_out   = rgb_q.r;
    assign green_out = rgb_q.g;
    assign blue_out  = rgb_q.b;
endmodule

// File: tb/tb_vga_bounce_renderer.sv
// Directed bench for vga_bounce_renderer with a frame-level reference model.
module tb_vga_bounce_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1, vs = 1'b1, on = 1'b0;
    logic [10:0] px = '0;
    logic [9:0]  py = '0;
    logic [1:0]  mode = '0;
    logic        h_sync_out, v_sync_out, frame_tick_out;
    logic [3:0]  red_out, green_out, blue_out;

    int vectors = 0;
    int fails   = 0;
    int nt      = 0;
    bit chk     = 1'b0;

    always #5 clk = ~clk;

    vga_bounce_renderer dut (
        .vga_clk_in(clk), .reset_in(rst),
        .h_sync_in(hs), .v_sync_in(vs), .display_on_in(on),
        .pixel_x_in(px), .pixel_y_in(py), .mode_in(mode),
        .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .frame_tick_out(frame_tick_out)
    );

    // Reference model: box position per frame, colour per pixel, 2-cycle delay line.
    int  mx, my, mmode;
    bit  mdx, mdy, mvprev;
    typedef struct packed { logic hs; logic vs; logic [11:0] rgb; } exp_t;
    exp_t e1, e2;
    logic etick;

    function automatic logic [11:0] ref_colour(input bit o, input int m, input int x,
                                               input int y, input int bx, input int by);
        int i;
        if (!o) return 12'h000;
        if (m == 3) return 12'h00F;
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 12'hFFF;
        if (m == 0) return 12'h000;
        if (m == 1) begin
            i = x / 80;
            return {{4{i[2]}}, {4{i[1]}}, {4{i[0]}}};
        end
        return (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 12'h888 : 12'h222;
    endfunction

    task automatic adv(inout int p, inout bit d, input int disp);
        if (d) begin
            if (p + 34 > disp) begin p = disp - 32; d = 1'b0; end
            else p = p + 2;
        end else begin
            if (p < 2) begin p = 0; d = 1'b1; end
            else p = p - 2;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mx = 0; my = 0; mdx = 1'b1; mdy = 1'b1; mmode = 0; mvprev = 1'b1;
            e1 = '{1'b1, 1'b1, 12'h000};
            e2 = e1;
            etick = 1'b0;
        end else begin
            e2 = e1;
            e1 = '{hs, vs, ref_colour(on, mmode, int'(px), int'(py), mx, my)};
            etick = mvprev && !vs;
            if (etick) begin
                adv(mx, mdx, 640);
                adv(my, mdy, 480);
                mmode = int'(mode);
            end
            mvprev = vs;
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            vectors++;
            if ({h_sync_out, v_sync_out, red_out, green_out, blue_out, frame_tick_out} !==
                {e2.hs, e2.vs, e2.rgb, etick}) begin
                fails++;
                $display("FAIL cycle @%0t: got hs=%b vs=%b rgb=%h tick=%b, want hs=%b vs=%b rgb=%h tick=%b",
                         $time, h_sync_out, v_sync_out, {red_out, green_out, blue_out},
                         frame_tick_out, e2.hs, e2.vs, e2.rgb, etick);
            end
        end
    end

    task automatic lit(input string name, input int got, input int want);
        vectors++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic drive(input bit h, input bit v, input bit o, input int x, input int y);
        @(negedge clk);
        hs = h; vs = v; on = o; px = 11'(x); py = 10'(y);
    endtask

    task automatic frame();
        drive(1'b1, 1'b0, 1'b0, 700, 490);
        drive(1'b1, 1'b1, 1'b0, 700, 490);
        nt++;
    endtask

    task automatic run_to(input int n);
        while (nt < n) frame();
    endtask

    task automatic probe_box();
        drive(1'b1, 1'b1, 1'b1, mx, my);
        drive(1'b1, 1'b1, 1'b1, mx - 1, my);
        drive(1'b1, 1'b1, 1'b1, mx + 31, my + 31);
        drive(1'b1, 1'b1, 1'b1, mx + 32, my);
        drive(1'b1, 1'b1, 1'b1, mx, my + 32);
        drive(1'b1, 1'b1, 0, 0, 0);
    endtask

    initial begin
        // Reset with junk on the inputs
        rst = 1'b1; hs = 1'b0; vs = 1'b0; on = 1'b1; px = 11'd5; py = 10'd5; mode = 2'd2;
        @(posedge clk);
        chk = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        lit("rst_hsync", int'(h_sync_out), 1);
        lit("rst_vsync", int'(v_sync_out), 1);
        lit("rst_rgb", int'({red_out, green_out, blue_out}), 0);
        lit("rst_tick", int'(frame_tick_out), 0);
        vs = 1'b1; mode = 2'd0;
        @(negedge clk);
        rst = 1'b0;

        // Compressed frame: pixel (0,0) first, then 3 short lines with h-sync pulses
        drive(1'b1, 1'b1, 1'b1, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        lit("pix00_latency2", int'({red_out, green_out, blue_out}), 12'hFFF);
        for (int y = 0; y < 3; y++) begin
            for (int x = (y == 0) ? 1 : 0; x < 48; x++) drive(1'b1, 1'b1, 1'b1, x, y);
            for (int b = 0; b < 4; b++) drive(b == 1 || b == 2 ? 1'b0 : 1'b1, 1'b1, 1'b0, 650 + b, y);
        end
        frame();
        lit("first_tick_x", mx, 2);
        lit("first_tick_y", my, 2);
        probe_box();

        // Right and bottom bounces
        run_to(224);
        lit("y224", my, 448); lit("dy224", int'(mdy), 1);
        frame();
        lit("y225", my, 448); lit("dy225", int'(mdy), 0);
        probe_box();
        frame();
        lit("y226", my, 446);
        run_to(304);
        lit("x304", mx, 608); lit("dx304", int'(mdx), 1);
        probe_box();
        frame();
        lit("x305", mx, 608); lit("dx305", int'(mdx), 0);
        frame();
        lit("x306", mx, 606); lit("y306", my, 286);
        probe_box();

        // Left bounce
        run_to(609);
        lit("x609", mx, 0); lit("dx609", int'(mdx), 0);
        frame();
        lit("x610", mx, 0); lit("dx610", int'(mdx), 1);
        probe_box();
        frame();
        lit("x611", mx, 2); lit("y611", my, 322);

        // Mode change mid-frame has no effect until the next tick
        mode = 2'd1;
        drive(1'b1, 1'b1, 1'b1, 85, 100);
        drive(1'b1, 1'b1, 1'b1, 600, 100);
        probe_box();
        frame();
        lit("mode_latched", mmode, 1);
        lit("bar1_model", int'(ref_colour(1'b1, mmode, 85, 100, mx, my)), 12'h00F);
        lit("bar7_model", int'(ref_colour(1'b1, mmode, 600, 100, mx, my)), 12'hFFF);
        drive(1'b1, 1'b1, 1'b1, 85, 100);
        drive(1'b1, 1'b1, 1'b1, 600, 100);
        for (int x = 0; x < 640; x += 40) drive(1'b1, 1'b1, 1'b1, x, 100);
        probe_box();

        // Checker
        mode = 2'd2;
        frame();
        lit("chk_dark", int'(ref_colour(1'b1, mmode, 40, 100, mx, my)), 12'h222);
        lit("chk_light", int'(ref_colour(1'b1, mmode, 32, 0, mx, my)), 12'h888);
        drive(1'b1, 1'b1, 1'b1, 40, 100);
        drive(1'b1, 1'b1, 1'b1, 32, 0);
        probe_box();

        // Solid blue ignores the box; blanking forces black
        mode = 2'd3;
        frame();
        lit("solid_in_box", int'(ref_colour(1'b1, mmode, mx + 1, my + 1, mx, my)), 12'h00F);
        drive(1'b1, 1'b1, 1'b1, mx + 1, my + 1);
        drive(1'b1, 1'b1, 1'b0, mx + 1, my + 1);
        probe_box();

        // Reset mid-frame: motion restarts at the origin, no spurious tick
        drive(1'b1, 1'b1, 1'b1, 300, 200);
        rst = 1'b1;
        repeat (2) drive(1'b0, 1'b1, 1'b1, 10, 10);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 0, 0);
        drive(1'b1, 1'b1, 1'b1, 31, 31);
        drive(1'b1, 1'b1, 1'b1, 32, 0);
        lit("rst_box_x", mx, 0);
        repeat (4) drive(1'b1, 1'b1, 1'b0, 0, 0);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
